// File: rtl/led_cmd_ctl.sv
// led_cmd_ctl: byte-stream command parser driving NUM_CH LED banks of LED_W
// bits. Each bank is shown static, blinking, or with its halves swapped
// while the button is held. Single clock domain (clk_rx).
module led_cmd_ctl #(
  parameter int NUM_CH     = 4,
  parameter int LED_W      = 8,
  parameter int BLINK_HALF = 31_250_000,
  parameter int TIMEOUT    = 1_250_000
) (
  input  logic                    clk_rx,
  input  logic                    rst_clk_rx,
  input  logic                    btn_clk_rx,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_rdy,
  output logic [NUM_CH*LED_W-1:0] led_o,
  output logic                    cmd_done,
  output logic                    cmd_err
);

  localparam int NB    = LED_W / 8;
  localparam int HALF  = LED_W / 2;
  localparam int CNT_W = $clog2(NB + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int BL_W  = $clog2(BLINK_HALF + 1);
  localparam logic [3:0] NCH = 4'(NUM_CH);

  localparam logic [1:0] M_STATIC = 2'd0;
  localparam logic [1:0] M_BLINK  = 2'd1;
  localparam logic [1:0] M_SWAP   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_MODE} state_t;

  state_t             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LED_W-1:0]   asm_q, asm_d;
  logic [2:0]         ch_q, ch_d;
  logic [LED_W-1:0]   value_q [NUM_CH];
  logic [LED_W-1:0]   value_d [NUM_CH];
  logic [1:0]         mode_q [NUM_CH];
  logic [1:0]         mode_d [NUM_CH];
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BL_W-1:0]    bl_cnt_q;
  logic               phase_q;
  logic [NUM_CH*LED_W-1:0] led_q, led_d;

  logic [1:0]         op;
  logic [2:0]         cmd_ch;
  logic               timeout;
  logic               new_ch_ok;
  logic               cur_ch_ok;
  logic [LED_W+7:0]   shift_w;

  assign op        = rx_data[7:6];
  assign cmd_ch    = rx_data[2:0];
  assign new_ch_ok = ({1'b0, cmd_ch} < NCH);
  assign cur_ch_ok = ({1'b0, ch_q} < NCH);
  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign shift_w   = {rx_data, asm_q};
  // The abort fires so that cmd_err lands TIMEOUT cycles after the last byte;
  // a strobe in that same cycle is parsed as a fresh command.
  assign timeout   = (state_q != S_IDLE) && (to_cnt_q == TO_W'(TIMEOUT - 2));

  // Command parser: next state, payload assembly, register-file updates.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    ch_d       = ch_q;
    value_d    = value_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (timeout) begin
      err_d    = 1'b1;
      state_d  = S_IDLE;
      to_cnt_d = '0;
    end

    if (state_q == S_IDLE || timeout) begin
      if (rx_data_rdy) begin
        case (op)
          2'b00: begin
            state_d    = S_DATA;
            byte_cnt_d = '0;
            ch_d       = cmd_ch;
            to_cnt_d   = '0;
          end
          2'b01: begin
            state_d  = S_MODE;
            ch_d     = cmd_ch;
            to_cnt_d = '0;
          end
          2'b10: begin
            if (new_ch_ok) begin
              for (int k = 0; k < NUM_CH; k++)
                if (cmd_ch == 3'(k)) value_d[k] = '0;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          default: begin
            for (int k = 0; k < NUM_CH; k++) begin
              value_d[k] = '0;
              mode_d[k]  = M_STATIC;
            end
            done_d = 1'b1;
          end
        endcase
      end
    end else if (rx_data_rdy) begin
      to_cnt_d = '0;
      if (state_q == S_DATA) begin
        asm_d = shift_w[LED_W+7:8];
        if (byte_cnt_q == CNT_W'(NB - 1)) begin
          state_d    = S_IDLE;
          byte_cnt_d = '0;
          if (cur_ch_ok) begin
            for (int k = 0; k < NUM_CH; k++)
              if (ch_q == 3'(k)) value_d[k] = shift_w[LED_W+7:8];
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = S_IDLE;
        if (cur_ch_ok && rx_data < 8'd3) begin
          for (int k = 0; k < NUM_CH; k++)
            if (ch_q == 3'(k)) mode_d[k] = rx_data[1:0];
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Parser and register-file state.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      state_q    <= S_IDLE;
      to_cnt_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      ch_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        value_q[k] <= '0;
        mode_q[k]  <= M_STATIC;
      end
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
      err_q      <= err_d;
      value_q    <= value_d;
      mode_q     <= mode_d;
    end
  end

  // Free-running blink timer; phase starts on and flips at every wrap.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      bl_cnt_q <= '0;
      phase_q  <= 1'b1;
    end else if (bl_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      bl_cnt_q <= '0;
      phase_q  <= ~phase_q;
    end else begin
      bl_cnt_q <= bl_cnt_q + BL_W'(1);
    end
  end

  // Per-channel display rendering from value, mode, phase and button.
  always_comb begin
    led_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      case (mode_q[k])
        M_BLINK: led_d[k*LED_W +: LED_W] = phase_q ? value_q[k] : '0;
        M_SWAP:  led_d[k*LED_W +: LED_W] = btn_clk_rx ?
                   {value_q[k][HALF-1:0], value_q[k][LED_W-1:HALF]} : value_q[k];
        default: led_d[k*LED_W +: LED_W] = value_q[k];
      endcase
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) led_q <= '0;
    else            led_q <= led_d;
  end

  assign led_o    = led_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

endmodule
